// File: rtl/dlx_mul_pkg.sv
// Shared definitions for the DLX sequential multiplier: FSM encoding,
// step/latency constants and the adder request bundle.
package dlx_mul_pkg;

    localparam int MUL_W     = 32;
    localparam int MUL_STEPS = 32;
    localparam int CNT_W     = 5;
    localparam int MUL_LAT_U = 33;
    localparam int MUL_LAT_S = 37;

    // NEG_* encodings are only reachable when DLX_MUL_SIGNED_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_FIN    = 3'd2,
        ST_NEG_A  = 3'd3,
        ST_NEG_B  = 3'd4,
        ST_NEG_LO = 3'd5,
        ST_NEG_HI = 3'd6
    } mul_state_t;

    typedef struct packed {
        logic [MUL_W-1:0] a;
        logic [MUL_W-1:0] b;
        logic             cin;
    } add_req_t;

endpackage

// File: rtl/dlx_seq_mul_adder.sv
// ADDER_DLX: carry-select adder, time-shared by the multiplier datapath.
// Each block precomputes sums for carry-in 0 and 1 and the ripple picks one.
module ADDER_DLX #(
    parameter int W   = 32,
    parameter int BLK = 8
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         CIN,
    output logic [W-1:0] S,
    output logic         COUT
);
    localparam int NB = W / BLK;

    logic [NB:0] c;

    assign c[0] = CIN;

    for (genvar i = 0; i < NB; i++) begin : g_blk
        logic [BLK:0] s0;
        logic [BLK:0] s1;

        assign s0 = {1'b0, A[i*BLK +: BLK]} + {1'b0, B[i*BLK +: BLK]};
        assign s1 = {1'b0, A[i*BLK +: BLK]} + {1'b0, B[i*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
        assign S[i*BLK +: BLK] = c[i] ? s1[BLK-1:0] : s0[BLK-1:0];
        assign c[i+1]          = c[i] ? s1[BLK]     : s0[BLK];
    end

    assign COUT = c[NB];

endmodule

// File: rtl/dlx_seq_mul.sv
// dlx_seq_mul: 32x32 shift-add multiplier, one step per clock through ADDER_DLX.
// Define DLX_MUL_SIGNED_EN to add the SIGNED port and the sign-fixup states.
module dlx_seq_mul
    import dlx_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef DLX_MUL_SIGNED_EN
    input  logic               SIGNED,
`endif
    output logic               BUSY,
    output logic               DONE,
    output logic [2*WIDTH-1:0] P
);

    mul_state_t       state;
    mul_state_t       state_nxt;

    logic [WIDTH-1:0] mc;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CNT_W-1:0] cnt;
    logic [2*WIDTH-1:0] p_q;
`ifdef DLX_MUL_SIGNED_EN
    logic             sgn;
    logic             neg;
    logic             negc;
`endif

    add_req_t         add_req;
    logic [WIDTH-1:0] add_s;
    logic             add_cout;
    logic             last_step;

    assign last_step = (cnt == CNT_W'(MUL_STEPS - 1));

    ADDER_DLX #(.W(WIDTH)) u_adder (
        .A    (add_req.a),
        .B    (add_req.b),
        .CIN  (add_req.cin),
        .S    (add_s),
        .COUT (add_cout)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
`ifdef DLX_MUL_SIGNED_EN
                if (START) state_nxt = ST_NEG_A;
`else
                if (START) state_nxt = ST_RUN;
`endif
            end
            ST_RUN: begin
`ifdef DLX_MUL_SIGNED_EN
                if (last_step) state_nxt = ST_NEG_LO;
`else
                if (last_step) state_nxt = ST_FIN;
`endif
            end
`ifdef DLX_MUL_SIGNED_EN
            ST_NEG_A:  state_nxt = ST_NEG_B;
            ST_NEG_B:  state_nxt = ST_RUN;
            ST_NEG_LO: state_nxt = ST_NEG_HI;
            ST_NEG_HI: state_nxt = ST_FIN;
`endif
            ST_FIN:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs and the single adder's input mux; negations are ~x + cin with B=0.
    always_comb begin
        BUSY        = (state != ST_IDLE);
        DONE        = (state == ST_FIN);
        add_req.a   = '0;
        add_req.b   = '0;
        add_req.cin = 1'b0;
        unique case (state)
            ST_RUN: begin
                add_req.a = hi;
                add_req.b = lo[0] ? mc : '0;
            end
`ifdef DLX_MUL_SIGNED_EN
            ST_NEG_A: begin
                add_req.a   = ~mc;
                add_req.cin = 1'b1;
            end
            ST_NEG_B, ST_NEG_LO: begin
                add_req.a   = ~lo;
                add_req.cin = 1'b1;
            end
            ST_NEG_HI: begin
                add_req.a   = ~hi;
                add_req.cin = negc;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mc   <= '0;
            hi   <= '0;
            lo   <= '0;
            cnt  <= '0;
            p_q  <= '0;
`ifdef DLX_MUL_SIGNED_EN
            sgn  <= 1'b0;
            neg  <= 1'b0;
            negc <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (START) begin
                        mc  <= A;
                        lo  <= B;
                        hi  <= '0;
                        cnt <= '0;
`ifdef DLX_MUL_SIGNED_EN
                        sgn <= SIGNED;
                        neg <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
`endif
                    end
                end
                ST_RUN: begin
                    // COUT lands in HI[31], so no unsigned carry is dropped.
                    hi  <= {add_cout, add_s[WIDTH-1:1]};
                    lo  <= {add_s[0], lo[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
`ifndef DLX_MUL_SIGNED_EN
                    if (last_step) p_q <= {add_cout, add_s, lo[WIDTH-1:1]};
`endif
                end
`ifdef DLX_MUL_SIGNED_EN
                ST_NEG_A: if (sgn && mc[WIDTH-1]) mc <= add_s;
                ST_NEG_B: if (sgn && lo[WIDTH-1]) lo <= add_s;
                ST_NEG_LO: begin
                    if (neg) begin
                        lo   <= add_s;
                        negc <= add_cout;
                    end
                end
                ST_NEG_HI: begin
                    if (neg) begin
                        hi  <= add_s;
                        p_q <= {add_s, lo};
                    end else begin
                        p_q <= {hi, lo};
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign P = p_q;

endmodule
